// File: rtl/i2c_read_rdata_if.sv
// Host and pin bundle for the I2C combined-format register reader.
// The slave modport is the reader's own view. The master modport is the host view, which also drives SDAI.
interface i2c_read_rdata_if;
  logic        GO;
  logic [7:0]  SLAVE_ADDRESS;
  logic [7:0]  REG_ADDR;
  logic [1:0]  BYTE_NUM;
  logic        SDAI;
  logic        SDAO;
  logic        SCLO;
  logic        END_OK;
  logic        ACK_ERR;
  logic [15:0] DATA;

  modport master (
    output GO, SLAVE_ADDRESS, REG_ADDR, BYTE_NUM, SDAI,
    input  SDAO, SCLO, END_OK, ACK_ERR, DATA
  );

  modport slave (
    input  GO, SLAVE_ADDRESS, REG_ADDR, BYTE_NUM, SDAI,
    output SDAO, SCLO, END_OK, ACK_ERR, DATA
  );
endinterface

// File: rtl/i2c_read_rdata.sv
// Bit-banged I2C combined-format read master: START, addr(W), reg, repeated START, addr(R), 1-2 data bytes, STOP.
// One PT_CK cycle is one quarter SCL period. The pins share the same timing as the register writer.
module i2c_read_rdata (
  input  logic                  PT_CK,
  input  logic                  RESET,
  i2c_read_rdata_if.slave       bus,
  output logic [2:0]            dbg_state
);
  // Handshake: END_OK=1 means idle/done. GO sampled 1 and then GO sampled 0 launches one transaction on the falling cycle.
  // While END_OK=0 the block ignores all host inputs.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_BYTE   = 3'd2,
    S_RSTART = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [2:0] B_ADDR_W = 3'd0;
  localparam logic [2:0] B_REG    = 3'd1;
  localparam logic [2:0] B_ADDR_R = 3'd2;
  localparam logic [2:0] B_DATA0  = 3'd3;
  localparam logic [2:0] B_DATA1  = 3'd4;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [7:0]  addr_q, reg_q;
  logic        two_q, nack_q;
  logic [15:0] sh_q;

  logic        sdao_d, sclo_d, end_ok_d, ack_err_d;
  logic [15:0] data_d;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  logic launch, sample, slave_slot, data_slot;
  assign launch     = (state_q == S_ARMED) && !bus.GO;
  assign sample     = (state_q == S_BYTE) && (phase_q == 2'd3);
  assign slave_slot = (byte_q <= B_ADDR_R);
  assign data_slot  = (byte_q >= B_DATA0);
  assign dbg_state  = state_q;

  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'd0;
      bit_q       <= 4'd0;
      byte_q      <= B_ADDR_W;
      addr_q      <= 8'h00;
      reg_q       <= 8'h00;
      two_q       <= 1'b0;
      nack_q      <= 1'b0;
      sh_q        <= 16'h0000;
      bus.SDAO    <= 1'b1;
      bus.SCLO    <= 1'b1;
      bus.END_OK  <= 1'b1;
      bus.ACK_ERR <= 1'b0;
      bus.DATA    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      bus.SDAO    <= sdao_d;
      bus.SCLO    <= sclo_d;
      bus.END_OK  <= end_ok_d;
      bus.ACK_ERR <= ack_err_d;
      bus.DATA    <= data_d;
      if (launch) begin
        addr_q <= bus.SLAVE_ADDRESS;
        reg_q  <= bus.REG_ADDR;
        two_q  <= (bus.BYTE_NUM >= 2'd2);
        nack_q <= 1'b0;
        sh_q   <= 16'h0000;
      end
      // The shift register starts cleared, so a single byte lands as {8'h00, b0}.
      if (sample && data_slot && (bit_q != 4'd8))
        sh_q <= {sh_q[14:0], bus.SDAI};
      if (sample && slave_slot && (bit_q == 4'd8) && bus.SDAI)
        nack_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE:  if (bus.GO) state_d = S_ARMED;
      S_ARMED: if (!bus.GO) begin
        state_d = S_BYTE;
        phase_d = 2'd0;
        bit_d   = 4'd0;
        byte_d  = B_ADDR_W;
      end
      S_BYTE: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (bit_q != 4'd8) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = 4'd0;
            if (slave_slot && bus.SDAI) state_d = S_STOP;
            else begin
              case (byte_q)
                B_ADDR_W: byte_d = B_REG;
                B_REG:    state_d = S_RSTART;
                B_ADDR_R: byte_d = B_DATA0;
                B_DATA0:  if (two_q) byte_d = B_DATA1; else state_d = S_STOP;
                default:  state_d = S_STOP;
              endcase
            end
          end
        end
      end
      S_RSTART: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          state_d = S_BYTE;
          byte_d  = B_ADDR_R;
        end
      end
      S_STOP: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd2) begin
          state_d = S_DONE;
          phase_d = 2'd0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (byte_q)
      B_ADDR_W: tx_byte = addr_q & 8'hFE;
      B_REG:    tx_byte = reg_q;
      B_ADDR_R: tx_byte = addr_q | 8'h01;
      default:  tx_byte = 8'hFF;
    endcase
    // In the ninth slot the master releases for the slave ACK, or ACKs a data byte only if another one follows.
    if (bit_q == 4'd8)
      tx_bit = data_slot ? !((byte_q == B_DATA0) && two_q) : 1'b1;
    else
      tx_bit = tx_byte[3'd7 - bit_q[2:0]];
  end

  always_comb begin
    sdao_d    = bus.SDAO;
    sclo_d    = bus.SCLO;
    end_ok_d  = bus.END_OK;
    ack_err_d = bus.ACK_ERR;
    data_d    = bus.DATA;
    case (state_q)
      S_ARMED: if (!bus.GO) begin
        sdao_d    = 1'b0;
        end_ok_d  = 1'b0;
        ack_err_d = 1'b0;
      end
      S_BYTE: case (phase_q)
        2'd0:    sclo_d = 1'b0;
        2'd1:    sdao_d = tx_bit;
        2'd2:    sclo_d = 1'b1;
        default: ;
      endcase
      S_RSTART: case (phase_q)
        2'd0:    sclo_d = 1'b0;
        2'd1:    sdao_d = 1'b1;
        2'd2:    sclo_d = 1'b1;
        default: sdao_d = 1'b0;
      endcase
      S_STOP: case (phase_q)
        2'd0:    begin sdao_d = 1'b0; sclo_d = 1'b0; end
        2'd1:    sclo_d = 1'b1;
        default: sdao_d = 1'b1;
      endcase
      S_DONE: begin
        end_ok_d  = 1'b1;
        ack_err_d = nack_q;
        if (!nack_q) data_d = sh_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_read_rdata.sv
// Directed bench for i2c_read_rdata: a schedule-driven slave responder and a pin monitor that records SDA at every SCL rise.
module tb_i2c_read_rdata;
  logic       PT_CK;
  logic       RESET;
  logic [2:0] dbg_state;
  i2c_read_rdata_if bus ();

  i2c_read_rdata dut (
    .PT_CK     (PT_CK),
    .RESET     (RESET),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial PT_CK = 1'b0;
  always #5 PT_CK = ~PT_CK;

  int compared;
  int mismatched;
  logic        sda_h [0:255];
  logic        scl_h [0:255];
  logic        eok_h [0:255];
  logic        aerr_h[0:255];
  logic [15:0] dat_h [0:255];
  int          starts;
  logic        obs_q[$];
  logic [0:0]  exp_q[$];

  // Slave response for the sample edge of cycle n after launch (slots: ADDR_W@1, REG@37, ADDR_R@77, D0@113, D1@149).
  function automatic logic slave_bit(input int n, input logic aw, input logic ar, input logic arr,
                                     input logic [7:0] d0, input logic [7:0] d1);
    int   k;
    logic r;
    r = 1'b1;
    if (n >= 1 && n <= 36) begin k = (n - 1) / 4; if (k == 8) r = !aw; end
    else if (n >= 37 && n <= 72) begin k = (n - 37) / 4; if (k == 8) r = !ar; end
    else if (n >= 77 && n <= 112) begin k = (n - 77) / 4; if (k == 8) r = !arr; end
    else if (n >= 113 && n <= 148) begin k = (n - 113) / 4; if (k < 8) r = d0[7-k]; end
    else if (n >= 149 && n <= 184) begin k = (n - 149) / 4; if (k < 8) r = d1[7-k]; end
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic ninth);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    exp_q.push_back(ninth);
  endtask

  task automatic run_txn(input logic [7:0] sa, input logic [7:0] ra, input logic [1:0] bn,
                         input logic aw, input logic ar, input logic arr,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input int rst_at, input logic go_hold, output int end_cyc);
    logic psda, pscl;
    obs_q.delete();
    starts  = 0;
    end_cyc = -1;
    bus.SLAVE_ADDRESS = sa;
    bus.REG_ADDR      = ra;
    bus.BYTE_NUM      = bn;
    bus.SDAI          = 1'b1;
    bus.GO            = 1'b1;
    @(posedge PT_CK); #1;
    bus.GO = 1'b0;
    psda = bus.SDAO;
    pscl = bus.SCLO;
    for (int n = 0; n < 256; n++) begin
      @(posedge PT_CK); #1;
      sda_h[n] = bus.SDAO; scl_h[n] = bus.SCLO; eok_h[n] = bus.END_OK;
      aerr_h[n] = bus.ACK_ERR; dat_h[n] = bus.DATA;
      if (bus.SCLO && !pscl) obs_q.push_back(bus.SDAO);
      if (pscl && bus.SCLO && psda && !bus.SDAO) starts++;
      psda = bus.SDAO;
      pscl = bus.SCLO;
      if (n == 0) begin
        bus.GO            = go_hold;
        bus.SLAVE_ADDRESS = ~sa;
        bus.REG_ADDR      = ~ra;
        bus.BYTE_NUM      = ~bn;
      end
      bus.SDAI = slave_bit(n + 1, aw, ar, arr, d0, d1);
      if (n == rst_at - 1) RESET = 1'b1;
      if (n == rst_at) begin RESET = 1'b0; break; end
      if (n > 0 && bus.END_OK) begin end_cyc = n; break; end
    end
  endtask

  task automatic check_stream(input string name);
    logic ok;
    ok = (obs_q.size() == exp_q.size());
    if (ok) for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i][0]) ok = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: sda stream got %0d bits, expected %0d bits with different content", name, obs_q.size(), exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    RESET = 1'b1; bus.GO = 1'b0; bus.SDAI = 1'b1;
    bus.SLAVE_ADDRESS = 8'h00; bus.REG_ADDR = 8'h00; bus.BYTE_NUM = 2'd1;
    repeat (3) @(posedge PT_CK);
    #1 RESET = 1'b0;
    @(posedge PT_CK); #1;
    compared++; if (bus.SDAO !== 1'b1) begin mismatched++; $display("FAIL reset_sdao: got %b expected 1", bus.SDAO); end
    compared++; if (bus.SCLO !== 1'b1) begin mismatched++; $display("FAIL reset_sclo: got %b expected 1", bus.SCLO); end
    compared++; if (bus.END_OK !== 1'b1) begin mismatched++; $display("FAIL reset_end_ok: got %b expected 1", bus.END_OK); end
    compared++; if (bus.ACK_ERR !== 1'b0) begin mismatched++; $display("FAIL reset_ack_err: got %b expected 0", bus.ACK_ERR); end
    compared++; if (bus.DATA !== 16'h0000) begin mismatched++; $display("FAIL reset_data: got %h expected 0000", bus.DATA); end
    compared++; if (dbg_state !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_read_one();
    int e;
    run_txn(8'h90, 8'h10, 2'd1, 1, 1, 1, 8'hA5, 8'hFF, -1, 1'b0, e);
    compared++; if (e !== 152) begin mismatched++; $display("FAIL one_end_cycle: got %0d expected 152", e); end
    compared++; if (eok_h[0] !== 1'b0) begin mismatched++; $display("FAIL one_busy_at_launch: got %b expected 0", eok_h[0]); end
    compared++; if (sda_h[2] !== 1'b1 || scl_h[2] !== 1'b0) begin mismatched++; $display("FAIL one_first_bit: got sda %b scl %b expected 1 0", sda_h[2], scl_h[2]); end
    compared++; if (scl_h[3] !== 1'b1) begin mismatched++; $display("FAIL one_first_scl_rise: got %b expected 1", scl_h[3]); end
    compared++; if (dat_h[151] !== 16'h0000) begin mismatched++; $display("FAIL one_data_early: got %h expected 0000", dat_h[151]); end
    compared++; if (dat_h[152] !== 16'h00A5) begin mismatched++; $display("FAIL one_data: got %h expected 00a5", dat_h[152]); end
    compared++; if (aerr_h[152] !== 1'b0) begin mismatched++; $display("FAIL one_ack_err: got %b expected 0", aerr_h[152]); end
    compared++; if (starts !== 2) begin mismatched++; $display("FAIL one_starts: got %0d expected 2", starts); end
    push_byte(8'h90, 1'b1); push_byte(8'h10, 1'b1); exp_q.push_back(1'b1);
    push_byte(8'h91, 1'b1); push_byte(8'hFF, 1'b1); exp_q.push_back(1'b0);
    check_stream("one_stream");
  endtask

  task automatic test_read_two();
    int e;
    run_txn(8'hA1, 8'h3C, 2'd2, 1, 1, 1, 8'h12, 8'h34, -1, 1'b0, e);
    compared++; if (e !== 188) begin mismatched++; $display("FAIL two_end_cycle: got %0d expected 188", e); end
    compared++; if (dat_h[188] !== 16'h1234) begin mismatched++; $display("FAIL two_data: got %h expected 1234", dat_h[188]); end
    compared++; if (aerr_h[188] !== 1'b0) begin mismatched++; $display("FAIL two_ack_err: got %b expected 0", aerr_h[188]); end
    push_byte(8'hA0, 1'b1); push_byte(8'h3C, 1'b1); exp_q.push_back(1'b1);
    push_byte(8'hA1, 1'b1); push_byte(8'hFF, 1'b0); push_byte(8'hFF, 1'b1); exp_q.push_back(1'b0);
    check_stream("two_stream");
  endtask

  task automatic test_no_slave();
    int e;
    run_txn(8'h90, 8'h10, 2'd1, 0, 0, 0, 8'hFF, 8'hFF, -1, 1'b0, e);
    compared++; if (e !== 40) begin mismatched++; $display("FAIL noslave_end_cycle: got %0d expected 40", e); end
    compared++; if (aerr_h[39] !== 1'b0) begin mismatched++; $display("FAIL noslave_ack_err_early: got %b expected 0", aerr_h[39]); end
    compared++; if (aerr_h[40] !== 1'b1) begin mismatched++; $display("FAIL noslave_ack_err: got %b expected 1", aerr_h[40]); end
    compared++; if (dat_h[40] !== 16'h1234) begin mismatched++; $display("FAIL noslave_data_kept: got %h expected 1234", dat_h[40]); end
    push_byte(8'h90, 1'b1); exp_q.push_back(1'b0);
    check_stream("noslave_stream");
  endtask

  task automatic test_reg_nack();
    int e;
    run_txn(8'h90, 8'h10, 2'd1, 1, 0, 1, 8'hA5, 8'hFF, -1, 1'b0, e);
    compared++; if (e !== 76) begin mismatched++; $display("FAIL regnack_end_cycle: got %0d expected 76", e); end
    compared++; if (aerr_h[0] !== 1'b0) begin mismatched++; $display("FAIL regnack_ack_err_clear: got %b expected 0", aerr_h[0]); end
    compared++; if (aerr_h[76] !== 1'b1) begin mismatched++; $display("FAIL regnack_ack_err: got %b expected 1", aerr_h[76]); end
    compared++; if (starts !== 1) begin mismatched++; $display("FAIL regnack_no_rstart: got %0d starts expected 1", starts); end
    compared++; if (dat_h[76] !== 16'h1234) begin mismatched++; $display("FAIL regnack_data_kept: got %h expected 1234", dat_h[76]); end
    push_byte(8'h90, 1'b1); push_byte(8'h10, 1'b1); exp_q.push_back(1'b0);
    check_stream("regnack_stream");
  endtask

  task automatic test_reset_mid();
    int e;
    run_txn(8'h90, 8'h10, 2'd2, 1, 1, 1, 8'h77, 8'h88, 60, 1'b0, e);
    compared++; if (sda_h[60] !== 1'b1 || scl_h[60] !== 1'b1) begin mismatched++; $display("FAIL rstmid_pins: got sda %b scl %b expected 1 1", sda_h[60], scl_h[60]); end
    compared++; if (eok_h[60] !== 1'b1) begin mismatched++; $display("FAIL rstmid_end_ok: got %b expected 1", eok_h[60]); end
    compared++; if (dat_h[60] !== 16'h0000) begin mismatched++; $display("FAIL rstmid_data: got %h expected 0000", dat_h[60]); end
    run_txn(8'h90, 8'h10, 2'd1, 1, 1, 1, 8'h5A, 8'hFF, -1, 1'b0, e);
    compared++; if (e !== 152) begin mismatched++; $display("FAIL rstmid_relaunch_end: got %0d expected 152", e); end
    compared++; if (dat_h[152] !== 16'h005A) begin mismatched++; $display("FAIL rstmid_relaunch_data: got %h expected 005a", dat_h[152]); end
  endtask

  task automatic test_go_held_bn0();
    int e;
    bus.GO = 1'b1;
    repeat (20) @(posedge PT_CK);
    #1;
    compared++; if (bus.END_OK !== 1'b1 || bus.SDAO !== 1'b1) begin mismatched++; $display("FAIL goheld_no_launch: got end_ok %b sdao %b expected 1 1", bus.END_OK, bus.SDAO); end
    compared++; if (dbg_state !== 3'd1) begin mismatched++; $display("FAIL goheld_armed: got %0d expected 1", dbg_state); end
    run_txn(8'h90, 8'h10, 2'd0, 1, 1, 1, 8'hC3, 8'hFF, -1, 1'b1, e);
    compared++; if (e !== 152) begin mismatched++; $display("FAIL bn0_end_cycle: got %0d expected 152", e); end
    compared++; if (dat_h[152] !== 16'h00C3) begin mismatched++; $display("FAIL bn0_data: got %h expected 00c3", dat_h[152]); end
    repeat (10) @(posedge PT_CK);
    #1;
    compared++; if (bus.END_OK !== 1'b1) begin mismatched++; $display("FAIL goheld_after_done: got %b expected 1", bus.END_OK); end
    bus.GO = 1'b0;
    @(posedge PT_CK); #1;
    compared++; if (bus.END_OK !== 1'b0) begin mismatched++; $display("FAIL goheld_fall_launch: got %b expected 0", bus.END_OK); end
    RESET = 1'b1;
    repeat (2) @(posedge PT_CK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_read_one();
    test_read_two();
    test_no_slave();
    test_reg_nack();
    test_reset_mid();
    test_go_held_bn0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/i2c_read_rdata.md
# i2c_read_rdata

Bit-banged I2C read master and the read-side counterpart of the team's I2C register writer. It performs a combined-format register read: START, slave address (write), register pointer, repeated START, slave address (read), then 1 or 2 data bytes, then STOP. It is driven by the same bit-phase tick clock and GO/END_OK handshake as the writer, so both blocks can share one SDA/SCL pin pair through an external mux.

## Interface
- No parameters.
- PT_CK  in  1  bit-phase clock; one cycle = one quarter SCL period.
- RESET  in  1  synchronous, active-high reset.
- GO  in  1  launch request, using the GO/END_OK handshake described below.
- SLAVE_ADDRESS  in  8  7-bit address in [7:1]; bit 0 is ignored. The block sends {[7:1],0} for the write phase and {[7:1],1} for the read phase.
- REG_ADDR  in  8  register pointer byte.
- BYTE_NUM  in  2  number of data bytes to read. 1 or 2; 0 is treated as 1, 3 is treated as 2.
- SDAI  in  1  sampled SDA line.
- SDAO  out  1  SDA drive; 1 = release/high.
- SCLO  out  1  SCL drive.
- END_OK  out  1  high = idle/done; low = transaction in progress.
- ACK_ERR  out  1  slave NACK seen in the last transaction.
- DATA  out  16  read result. N=1 gives {8'h00, b0}; N=2 gives {b0, b1}, where b0 is the first byte received.

## Operation
- Reset values: SDAO=1, SCLO=1, END_OK=1, ACK_ERR=0, DATA=0. State goes to IDLE.
- IDLE: SDAO=1 and SCLO=1.
  - GO sampled 1 moves to ARMED.
  - In ARMED, GO sampled 0 is the launch cycle L. On L:
    - END_OK<=0 and ACK_ERR<=0.
    - SDAO<=0 with SCLO=1, which is the START condition.
    - SLAVE_ADDRESS, REG_ADDR and BYTE_NUM are latched.
- Bit slot = 4 cycles, P0..P3:
  - P0: SCLO<=0.
  - P1: SDAO<=bit.
  - P2: SCLO<=1.
  - P3: SCLO held 1; SDAI sampled at the end of P3.
- Byte slot = 9 bit slots, MSB first. The 9th bit is the ACK slot.
- Byte sequence:
  - ADDR_W, then REG, each followed by a slave ACK slot (SDAO=1 in the 9th bit).
  - Repeated START, 4 cycles: SCLO<=0; SDAO<=1; SCLO<=1; SDAO<=0.
  - ADDR_R, followed by a slave ACK slot.
  - N read bytes. For the 8 data bits SDAO=1 and SDAI is shifted in. In the 9th bit the master drives SDAO=0 (ACK) if more bytes remain, else SDAO=1 (NACK).
- STOP, 3 cycles: {SDAO,SCLO}<=00; then 01; then 11. The following cycle sets END_OK<=1 and loads DATA, then returns to IDLE.
- Slave NACK (SDAI=1 at P3 of a slave ACK slot):
  - ACK_ERR<=1.
  - The remaining bytes are skipped and the block goes straight to STOP.
  - DATA is not updated and keeps its previous value.
- Inputs are ignored while busy. GO activity during a transaction has no effect; a new launch requires GO 1 then 0 after END_OK=1.
- RESET mid-transaction: the next cycle shows reset values (SDA/SCL released) and any partial data is discarded.

## Timing
- Cycle L = 0.
- END_OK rises at cycle 36·(3+N)+8 with no NACK: 152 for N=1, 188 for N=2.
- ADDR_W MSB appears on SDAO at cycle 2. SCL first rises at cycle 3.
- NACK on ADDR_W: the ACK slot ends at cycle 36 and END_OK rises at cycle 40.
- NACK on REG: END_OK rises at cycle 76.
- NACK on ADDR_R: END_OK rises at cycle 116.
- DATA and ACK_ERR change only on the END_OK rising cycle; ACK_ERR also clears at L.
- SDAO changes only while SCLO=0, except in START, repeated START and STOP.

## Test plan
- Slave model at address 0x48 returns 0xA5 for REG_ADDR=0x10, N=1 -> END_OK rises at cycle 152, DATA=0x00A5, ACK_ERR=0, and master NACK on the last byte.
- N=2, slave returns 0x12 then 0x34 -> master ACKs the first byte and NACKs the second; DATA=0x1234; END_OK at cycle 188.
- No slave (SDAI stuck 1) -> ACK_ERR=1, END_OK at cycle 40, DATA retains its prior value 0x1234.
- Slave NACKs REG only -> ACK_ERR=1, END_OK at cycle 76, repeated START is never issued.
- RESET asserted at cycle 60 -> next cycle SDAO=1, SCLO=1, END_OK=1, DATA=0. A new GO pulse then completes normally.
- GO held high through the whole transaction, and BYTE_NUM=0 -> no launch until GO falls; BYTE_NUM=0 then behaves as N=1 (152 cycles).
